// File: rtl/pkg_cronometro.sv
// Shared definitions for the stopwatch limit-entry block: sizes, FSM encoding
// and BCD digit helpers.
package pkg_cronometro;

  localparam int WIDTH_DEF = 14;
  localparam int NDIG_DEF  = 4;
  localparam int DEB_DEF   = 16;

  localparam logic [3:0] DIG_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } estado_t;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= DIG_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? DIG_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/botao_borda.sv
// Button conditioning: 2-flop synchronizer, optional debounce filter
// (AJUSTE_DEBOUNCE_EN) and a single-cycle rising-edge pulse.
module botao_borda #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic s1_q, s2_q, prev_q, lvl;

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("botao_borda: DEB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s2_q ^ (s1_q ^ s2_q);
    end
  end

`ifdef AJUSTE_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flt_q, flt_d;

  // Down-counter restarts whenever the input agrees with the filtered level.
  always_comb begin
    cnt_d = cnt_q;
    flt_d = flt_q;
    if (s2_q == flt_q) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q == '0) begin
      flt_d = s2_q;
      cnt_d = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_LOAD;
      flt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      flt_q <= flt_d;
    end
  end

  assign lvl = flt_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= lvl;
  end

  assign pulse = lvl & ~prev_q;

endmodule

// File: rtl/ajuste_limite.sv
// Operator limit entry: edits NDIG BCD digits from four buttons and, on confirm,
// converts them to binary by repeated multiply-by-10. Debounce via AJUSTE_DEBOUNCE_EN.
module ajuste_limite
  import pkg_cronometro::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int NDIG       = NDIG_DEF,
  parameter int DEB_CYCLES = DEB_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              btn_sel,
  input  logic              btn_ok,
  output logic [WIDTH-1:0]  limite,
  output logic              limite_valid,
  output logic [4*NDIG-1:0] digitos,
  output logic [1:0]        cursor,
  output logic              busy
);

  localparam logic [1:0] IDX_LAST = 2'(NDIG - 1);

  if (NDIG < 1 || NDIG > 4 || (10.0 ** NDIG) - 1.0 >= (2.0 ** WIDTH)) begin : g_bad_size
    $error("ajuste_limite: NDIG must be 1..4 and 10^NDIG-1 must fit in WIDTH bits");
  end

  logic ev_inc, ev_dec, ev_sel, ev_ok;

  botao_borda #(.DEB_CYCLES(DEB_CYCLES)) u_inc (.clk(clk), .reset(reset), .btn(btn_inc), .pulse(ev_inc));
  botao_borda #(.DEB_CYCLES(DEB_CYCLES)) u_dec (.clk(clk), .reset(reset), .btn(btn_dec), .pulse(ev_dec));
  botao_borda #(.DEB_CYCLES(DEB_CYCLES)) u_sel (.clk(clk), .reset(reset), .btn(btn_sel), .pulse(ev_sel));
  botao_borda #(.DEB_CYCLES(DEB_CYCLES)) u_ok  (.clk(clk), .reset(reset), .btn(btn_ok),  .pulse(ev_ok));

  estado_t          state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       cur_q, cur_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [3:0]       dig_q [NDIG];
  logic [3:0]       dig_d [NDIG];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EDIT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EDIT: if (ev_ok) state_d = ST_CONV;
      ST_CONV: if (idx_q == 2'd0) state_d = ST_DONE;
      ST_DONE: state_d = ST_EDIT;
      default: state_d = ST_EDIT;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = (state_q == ST_CONV);
    limite_valid = (state_q == ST_DONE);
  end

  // acc*10 as shift-add; the size check above guarantees no overflow.
  assign acc_next = (acc_q << 3) + (acc_q << 1) + WIDTH'(dig_q[idx_q]);

  // The final conversion step loads limite directly so it and limite_valid move together.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    lim_d = lim_q;
    cur_d = cur_q;
    dig_d = dig_q;
    case (state_q)
      ST_EDIT: begin
        if (ev_ok) begin
          acc_d = '0;
          idx_d = IDX_LAST;
        end else begin
          if (ev_inc && !ev_dec)      dig_d[cur_q] = bcd_inc(dig_q[cur_q]);
          else if (ev_dec && !ev_inc) dig_d[cur_q] = bcd_dec(dig_q[cur_q]);
          if (ev_sel) cur_d = (cur_q == IDX_LAST) ? 2'd0 : cur_q + 2'd1;
        end
      end
      ST_CONV: begin
        acc_d = acc_next;
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) lim_d = acc_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      idx_q <= '0;
      lim_q <= '0;
      cur_q <= '0;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= 4'd0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      lim_q <= lim_d;
      cur_q <= cur_d;
      dig_q <= dig_d;
    end
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign digitos[4*g +: 4] = dig_q[g];
  end

  assign limite = lim_q;
  assign cursor = cur_q;

endmodule

// File: tb/tb_ajuste_limite.sv
// Self-checking bench for ajuste_limite: table sequence, corner sequences and
// random button presses against a digit-level reference model.
module tb_ajuste_limite;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_inc, btn_dec, btn_sel, btn_ok;
  logic [13:0] limite;
  logic        limite_valid;
  logic [15:0] digitos;
  logic [1:0]  cursor;
  logic        busy;

  always #5 clk = ~clk;

  ajuste_limite #(.WIDTH(14), .NDIG(4), .DEB_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_sel(btn_sel), .btn_ok(btn_ok),
    .limite(limite), .limite_valid(limite_valid),
    .digitos(digitos), .cursor(cursor), .busy(busy)
  );

`ifdef AJUSTE_DEBOUNCE_EN
  localparam int DL = 16;
`else
  localparam int DL = 0;
`endif
  localparam int HOLD = DL + 3;
  localparam int GAP  = DL + 4;

  int n_cmp = 0;
  int n_bad = 0;
  int md[4];
  int mc;
  int mlim;

  typedef struct {
    bit   i, d, s;
    int   exp_dig;
    int   exp_cur;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int model_bcd();
    return md[3] * 4096 + md[2] * 256 + md[1] * 16 + md[0];
  endfunction

  function automatic int model_val();
    return md[3] * 1000 + md[2] * 100 + md[1] * 10 + md[0];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit i, input bit d, input bit s);
    btn_inc = i; btn_dec = d; btn_sel = s;
    tick(HOLD);
    btn_inc = 0; btn_dec = 0; btn_sel = 0;
    tick(GAP);
    if (i != d) md[mc] = i ? (md[mc] + 1) % 10 : (md[mc] + 9) % 10;
    if (s) mc = (mc + 1) % 4;
    chk("press digitos", int'(digitos), model_bcd());
    chk("press cursor", int'(cursor), mc);
  endtask

  // Confirm; optionally with inc pressed on the same cycle, or a burst during CONV.
  task automatic do_ok(input bit with_inc, input bit burst);
    int first, cnt, dig0, cur0;
    dig0 = model_bcd();
    cur0 = mc;
    first = 0;
    cnt = 0;
    btn_ok = 1; btn_inc = with_inc;
    for (int k = 1; k <= DL + 11; k++) begin
      tick(1);
      if (k == DL + 3) begin
        btn_ok = 0; btn_inc = 0;
        chk("busy at conv start", int'(busy), 1);
        if (burst) begin
          btn_inc = 1; btn_dec = 0; btn_sel = 1;
        end
      end
      if (k == DL + 5) begin
        btn_inc = 0; btn_sel = 0;
      end
      if (k == DL + 6) chk("busy at conv end", int'(busy), 1);
      if (k == DL + 7) chk("busy after conv", int'(busy), 0);
      if (limite_valid) begin
        cnt++;
        if (first == 0) first = k;
        chk("limite on strobe", int'(limite), model_val());
      end
    end
    mlim = model_val();
    chk("strobe latency", first, DL + 7);
    chk("strobe width", cnt, 1);
    tick(GAP);
    chk("digitos after ok", int'(digitos), dig0);
    chk("cursor after ok", int'(cursor), cur0);
    chk("limite held", int'(limite), mlim);
  endtask

  initial begin
    bit [2:0] r;
    int vcnt;
    vecs[0] = '{1, 0, 0, 16'h0001, 0};
    vecs[1] = '{1, 0, 0, 16'h0002, 0};
    vecs[2] = '{1, 0, 0, 16'h0003, 0};
    vecs[3] = '{0, 0, 1, 16'h0003, 1};
    vecs[4] = '{1, 0, 0, 16'h0013, 1};
    vecs[5] = '{1, 0, 0, 16'h0023, 1};
    vecs[6] = '{0, 0, 1, 16'h0023, 2};
    vecs[7] = '{0, 0, 1, 16'h0023, 3};
    vecs[8] = '{1, 0, 0, 16'h1023, 3};

    reset = 1; btn_inc = 0; btn_dec = 0; btn_sel = 0; btn_ok = 0;
    for (int j = 0; j < 4; j++) md[j] = 0;
    mc = 0; mlim = 0;
    tick(3);
    reset = 0;
    tick(1);
    chk("reset digitos", int'(digitos), 0);
    chk("reset cursor", int'(cursor), 0);
    chk("reset limite", int'(limite), 0);
    chk("reset valid", int'(limite_valid), 0);
    chk("reset busy", int'(busy), 0);

    for (int v = 0; v < 9; v++) begin
      press(vecs[v].i, vecs[v].d, vecs[v].s);
      chk($sformatf("vec%0d digitos", v), int'(digitos), vecs[v].exp_dig);
      chk($sformatf("vec%0d cursor", v), int'(cursor), vecs[v].exp_cur);
    end
    do_ok(0, 0);
    chk("limite 1023", int'(limite), 1023);

    // Wraps: cursor 3 -> 0, then digit 2 (value 0) down to 9 and back up to 0.
    press(0, 0, 1);
    chk("cursor wrap", int'(cursor), 0);
    press(0, 0, 1);
    press(0, 0, 1);
    press(0, 1, 0);
    chk("dec wrap 0->9", int'(digitos), 16'h1923);
    press(1, 0, 0);
    chk("inc wrap 9->0", int'(digitos), 16'h1023);
    for (int j = 0; j < 4; j++) press(0, 0, 1);
    chk("sel x4 cursor", int'(cursor), 2);

    press(1, 1, 0);
    chk("inc+dec no change", int'(digitos), 16'h1023);
    press(1, 0, 1);
    chk("sel+inc digit", int'(digitos), 16'h1123);
    chk("sel+inc cursor", int'(cursor), 3);
    do_ok(1, 0);
    chk("ok+inc limite", int'(limite), 1123);

    // All nines, then edit without confirm.
    for (int c = 0; c < 4; c++) begin
      while (md[mc] != 9) press(1, 0, 0);
      press(0, 0, 1);
    end
    do_ok(0, 0);
    chk("limite 9999", int'(limite), 14'h270F);
    while (mc != 0) press(0, 0, 1);
    press(0, 1, 0);
    chk("unidade 8", int'(digitos), 16'h9998);
    chk("limite kept 9999", int'(limite), 9999);
    do_ok(0, 1);
    chk("limite 9998", int'(limite), 9998);
    do_ok(0, 0);

    // Reset during the second conversion cycle.
    btn_ok = 1;
    for (int k = 1; k <= DL + 4; k++) tick(1);
    chk("busy before reset", int'(busy), 1);
    reset = 1; btn_ok = 0;
    tick(1);
    reset = 0;
    for (int j = 0; j < 4; j++) md[j] = 0;
    mc = 0; mlim = 0;
    chk("mid-conv reset limite", int'(limite), 0);
    chk("mid-conv reset busy", int'(busy), 0);
    chk("mid-conv reset digitos", int'(digitos), 0);
    vcnt = 0;
    for (int k = 0; k < DL + 10; k++) begin
      tick(1);
      if (limite_valid) vcnt++;
    end
    chk("no strobe after reset", vcnt, 0);
    press(1, 0, 0);
    chk("edit after reset", int'(digitos), 16'h0001);

`ifdef AJUSTE_DEBOUNCE_EN
    btn_inc = 1; tick(5); btn_inc = 0; tick(GAP + DL);
    chk("glitch ignored", int'(digitos), model_bcd());
    btn_inc = 1; tick(20); btn_inc = 0; tick(GAP + DL);
    md[mc] = (md[mc] + 1) % 10;
    chk("long press one inc", int'(digitos), model_bcd());
`endif

    for (int n = 0; n < 80; n++) begin
      r = 3'($urandom_range(0, 7));
      press(r[0], r[1], r[2]);
      if (n % 10 == 9) do_ok(0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ajuste_limite.md
Name: ajuste_limite

Overview:
- Operator-side limit entry for the stopwatch: four push-buttons edit a 4-digit decimal value (0000–9999).
- On confirm, converts BCD to binary and presents it on a 14-bit `limite` bus with a one-cycle `limite_valid` strobe. This bus is the stopwatch counter's limit input.
- Also exports the BCD digits and the cursor position, so the 7-segment path can show the value during editing.
- Sequential: button edge detection, edit/convert FSM, iterative multiply-by-10 conversion.

Parameters:
- WIDTH, 14, width of `limite`. The rule 10^NDIG − 1 < 2^WIDTH must hold.
- NDIG, 4, number of decimal digits. Digit 0 = unidade, 3 = milhar.
- DEB_CYCLES, 16, stable-sample count for the debounce filter. Used only with AJUSTE_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- btn_inc  in  1  level button: increment the selected digit.
- btn_dec  in  1  level button: decrement the selected digit.
- btn_sel  in  1  level button: advance the cursor.
- btn_ok  in  1  level button: confirm and convert.
- limite  out  WIDTH  binary limit; holds its value until the next confirm.
- limite_valid  out  1  one-cycle pulse when `limite` is updated.
- digitos  out  4*NDIG  BCD digits; [3:0] = unidade.
- cursor  out  2  index of the digit being edited.
- busy  out  1  high while converting.

Behaviour:
- Reset values (reset sampled high on a clk edge): digitos=0, cursor=0, limite=0, limite_valid=0, busy=0, FSM=EDIT, edge-detect history cleared.
- Reset dominates every other input in every state, including mid-CONV. A partial result is discarded and `limite` returns to 0.
- Input path: each button goes through a 2-flop synchronizer, then a rising-edge detector. One press produces exactly one action, whatever the hold time.
- FSM states: EDIT, CONV, DONE.
- EDIT:
  - inc edge: digit[cursor] +1; 9 wraps to 0.
  - dec edge: digit[cursor] −1; 0 wraps to 9.
  - inc and dec edges in the same cycle: no change.
  - sel edge: cursor +1; NDIG−1 wraps to 0.
  - sel together with inc or dec: the digit update uses the old cursor, and the cursor advances in the same cycle.
  - ok edge: has priority over all other edges, which are discarded that cycle. Clears acc, sets idx=NDIG−1, moves to CONV, busy=1.
- CONV (NDIG cycles):
  - Each cycle: acc ← acc*10 + digit[idx], then idx−1.
  - acc*10 is computed as (acc<<3)+(acc<<1), WIDTH bits; overflow is impossible by the parameter rule.
  - After idx=0 is processed, move to DONE.
  - All button edges are ignored in this state.
- DONE (1 cycle): limite←acc, limite_valid=1, busy=0, then EDIT.
- Latency:
  - The ok edge is detected 2 cycles after btn_ok rises (synchronizer).
  - limite_valid is high NDIG+1 cycles after the ok-edge cycle (5 for NDIG=4).
  - `limite` and `limite_valid` change on the same edge.
- Digits are not cleared by confirm; a re-confirm without edits re-emits the same value with a new strobe.
- limite_valid is never high for two consecutive cycles.

Optional Feature:
- Macro: AJUSTE_DEBOUNCE_EN.
- Defined: a per-button counter sits between the synchronizer and the edge detector. The filtered level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles. Edge latency grows by DEB_CYCLES.
- Undefined: no filter. Button inputs are assumed clean; edge latency is 2 cycles.

Decomposition:
- Shared package (pkg_cronometro): WIDTH/NDIG defaults, FSM state encoding (EDIT, CONV, DONE), BCD constants (digit max 9).
- Sub-module `botao_borda`: synchronizer, optional debounce, rising-edge pulse. Instantiated 4 times.
- The top level holds the FSM, digit registers and conversion datapath.

Test Plan:
- Reset → all outputs 0. inc×3, sel, inc×2, sel, sel, inc×1, ok → digitos=1023 (BCD) and, 7 cycles after btn_ok rises, limite=1023 with a 1-cycle limite_valid pulse.
- All digits at 9, ok → limite=9999 (14'h270F). Then dec on unidade → digit 8 and limite still 9999 until the next ok.
- Wrap: dec at 0 → 9; inc at 9 → 0; sel×4 → cursor back to 0.
- inc+dec same cycle → no change; sel+inc same cycle → old digit incremented, cursor+1; ok+inc same cycle → only the conversion starts.
- Button presses during CONV → no digit or cursor change. Reset asserted at the 2nd CONV cycle → limite=0, no limite_valid, FSM in EDIT.
- With AJUSTE_DEBOUNCE_EN, DEB_CYCLES=16: a 5-cycle glitch on btn_inc → no change; a 20-cycle press → exactly one increment.
